// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and sizing helper for the PISO transmitter
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: counts bits shifted out of the current word, saturating at WIDTH-1
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && !last)
            count <= count + CW'(1);
    end

    assign last = count == CW'(WIDTH - 1);

endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter with valid/ready load and en-strobed shifting
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             last, hs, shift, last_en, out_n;

    // a word may be accepted on the same edge that retires the previous one
    assign last_en    = state == ST_SHIFT && en && last;
    assign load_ready = !reset && (state == ST_IDLE || last_en);
    assign hs         = load_valid && load_ready;
    assign shift      = state == ST_SHIFT && en && !last;

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (hs),
        .inc   (shift),
        .last  (last)
    );

    always_comb begin
        state_n = hs ? ST_SHIFT : last_en ? ST_IDLE : state;
        shreg_n = hs ? load_data : shift ? (LSB_FIRST ? shreg >> 1 : shreg << 1) : shreg;
        out_n   = state_n == ST_SHIFT ? (LSB_FIRST ? shreg_n[0] : shreg_n[WIDTH-1]) : IDLE_LEVEL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // serial_out mirrors the output end of the next shift register value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg      <= '0;
            serial_out <= IDLE_LEVEL;
            frame      <= 1'b0;
            done       <= 1'b0;
        end else begin
            shreg      <= shreg_n;
            serial_out <= out_n;
            frame      <= state_n == ST_SHIFT;
            done       <= last_en;
        end
    end

endmodule
